// File: rtl/id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg
//   ID/EX pipeline register with load-use hazard detection.
//   Captures the decoded operands, register addresses and controls of the ID
//   instruction on every rising CLK edge. When the instruction in EX is a load
//   whose destination (rt) is a source of the ID instruction, PC and IF/ID are
//   held for one cycle and a bubble is written into EX. A Flush from a taken
//   branch/jump also turns the register into a bubble.
//
// Ports
//   CLK, Reset            clock (rising edge), synchronous active-high reset
//   Flush                 squash the instruction entering EX
//   ID_*                  decoded instruction fields from the ID stage
//   EX_*                  registered copies of the ID_* fields, plus EX_valid
//   PCWre, IF_ID_Wre      0 = hold PC / IF/ID this cycle
//   LoadUseStall          combinational load-use detect
//   StallCount            saturating count of inserted load-use bubbles
// -----------------------------------------------------------------------------
module id_ex_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 3
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Flush,
    input  logic               ID_valid,
    input  logic [DATA_W-1:0]  ID_PC4,
    input  logic [DATA_W-1:0]  ID_ReadData1,
    input  logic [DATA_W-1:0]  ID_ReadData2,
    input  logic [DATA_W-1:0]  ID_Imm,
    input  logic [REG_AW-1:0]  ID_rs,
    input  logic [REG_AW-1:0]  ID_rt,
    input  logic [REG_AW-1:0]  ID_rd,
    input  logic               ID_UsesRt,
    input  logic               ID_RegWre,
    input  logic               ID_mRD,
    input  logic               ID_mWR,
    input  logic               ID_ALUSrcA,
    input  logic               ID_ALUSrcB,
    input  logic               ID_DBDataSrc,
    input  logic [1:0]         ID_RegDst,
    input  logic [ALUOP_W-1:0] ID_ALUOp,
    output logic               EX_valid,
    output logic [DATA_W-1:0]  EX_PC4,
    output logic [DATA_W-1:0]  EX_ReadData1,
    output logic [DATA_W-1:0]  EX_ReadData2,
    output logic [DATA_W-1:0]  EX_Imm,
    output logic [REG_AW-1:0]  EX_rs,
    output logic [REG_AW-1:0]  EX_rt,
    output logic [REG_AW-1:0]  EX_rd,
    output logic               EX_UsesRt,
    output logic               EX_RegWre,
    output logic               EX_mRD,
    output logic               EX_mWR,
    output logic               EX_ALUSrcA,
    output logic               EX_ALUSrcB,
    output logic               EX_DBDataSrc,
    output logic [1:0]         EX_RegDst,
    output logic [ALUOP_W-1:0] EX_ALUOp,
    output logic               PCWre,
    output logic               IF_ID_Wre,
    output logic               LoadUseStall,
    output logic [15:0]        StallCount
);

    typedef struct packed {
        logic               valid;
        logic [DATA_W-1:0]  pc4;
        logic [DATA_W-1:0]  read_data1;
        logic [DATA_W-1:0]  read_data2;
        logic [DATA_W-1:0]  imm;
        logic [REG_AW-1:0]  rs;
        logic [REG_AW-1:0]  rt;
        logic [REG_AW-1:0]  rd;
        logic               uses_rt;
        logic               reg_wre;
        logic               m_rd;
        logic               m_wr;
        logic               alu_src_a;
        logic               alu_src_b;
        logic               db_data_src;
        logic [1:0]         reg_dst;
        logic [ALUOP_W-1:0] alu_op;
    } ex_t;

    ex_t         ex_q, ex_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic        load_use_stall;

    // Loads always write rt, so only EX_rt is compared; reg 0 never hazards.
    always_comb begin
        load_use_stall = ex_q.valid & ex_q.m_rd & ex_q.reg_wre & ID_valid
                       & (ex_q.rt != '0)
                       & ((ex_q.rt == ID_rs) | (ID_UsesRt & (ex_q.rt == ID_rt)));
    end

    always_comb begin
        ex_d             = '0;
        ex_d.valid       = ID_valid;
        ex_d.pc4         = ID_PC4;
        ex_d.read_data1  = ID_ReadData1;
        ex_d.read_data2  = ID_ReadData2;
        ex_d.imm         = ID_Imm;
        ex_d.rs          = ID_rs;
        ex_d.rt          = ID_rt;
        ex_d.rd          = ID_rd;
        ex_d.uses_rt     = ID_UsesRt;
        if (ID_valid) begin
            ex_d.reg_wre     = ID_RegWre;
            ex_d.m_rd        = ID_mRD;
            ex_d.m_wr        = ID_mWR;
            ex_d.alu_src_a   = ID_ALUSrcA;
            ex_d.alu_src_b   = ID_ALUSrcB;
            ex_d.db_data_src = ID_DBDataSrc;
            ex_d.reg_dst     = ID_RegDst;
            ex_d.alu_op      = ID_ALUOp;
        end
        // A bubble clears addresses too, so it can never match a forwarding
        // compare downstream.
        if (Flush || load_use_stall) begin
            ex_d = '0;
        end
    end

    // A flush already bubbles EX, so the coincident stall is not a new bubble.
    always_comb begin
        stall_count_d = stall_count_q;
        if (load_use_stall && !Flush && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            ex_q          <= '0;
            stall_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign EX_valid     = ex_q.valid;
    assign EX_PC4       = ex_q.pc4;
    assign EX_ReadData1 = ex_q.read_data1;
    assign EX_ReadData2 = ex_q.read_data2;
    assign EX_Imm       = ex_q.imm;
    assign EX_rs        = ex_q.rs;
    assign EX_rt        = ex_q.rt;
    assign EX_rd        = ex_q.rd;
    assign EX_UsesRt    = ex_q.uses_rt;
    assign EX_RegWre    = ex_q.reg_wre;
    assign EX_mRD       = ex_q.m_rd;
    assign EX_mWR       = ex_q.m_wr;
    assign EX_ALUSrcA   = ex_q.alu_src_a;
    assign EX_ALUSrcB   = ex_q.alu_src_b;
    assign EX_DBDataSrc = ex_q.db_data_src;
    assign EX_RegDst    = ex_q.reg_dst;
    assign EX_ALUOp     = ex_q.alu_op;

    // Flush does not hold fetch; the redirect is handled upstream.
    assign LoadUseStall = load_use_stall;
    assign PCWre        = ~load_use_stall;
    assign IF_ID_Wre    = ~load_use_stall;
    assign StallCount   = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int OW = 3;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic          Reset, Flush, ID_valid;
    logic [DW-1:0] ID_PC4, ID_ReadData1, ID_ReadData2, ID_Imm;
    logic [AW-1:0] ID_rs, ID_rt, ID_rd;
    logic          ID_UsesRt, ID_RegWre, ID_mRD, ID_mWR, ID_ALUSrcA, ID_ALUSrcB, ID_DBDataSrc;
    logic [1:0]    ID_RegDst;
    logic [OW-1:0] ID_ALUOp;
    logic          EX_valid;
    logic [DW-1:0] EX_PC4, EX_ReadData1, EX_ReadData2, EX_Imm;
    logic [AW-1:0] EX_rs, EX_rt, EX_rd;
    logic          EX_UsesRt, EX_RegWre, EX_mRD, EX_mWR, EX_ALUSrcA, EX_ALUSrcB, EX_DBDataSrc;
    logic [1:0]    EX_RegDst;
    logic [OW-1:0] EX_ALUOp;
    logic          PCWre, IF_ID_Wre, LoadUseStall;
    logic [15:0]   StallCount;

    id_ex_stage_reg #(.DATA_W(DW), .REG_AW(AW), .ALUOP_W(OW)) dut (
        .CLK(CLK), .Reset(Reset), .Flush(Flush), .ID_valid(ID_valid),
        .ID_PC4(ID_PC4), .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
        .ID_Imm(ID_Imm), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd),
        .ID_UsesRt(ID_UsesRt), .ID_RegWre(ID_RegWre), .ID_mRD(ID_mRD), .ID_mWR(ID_mWR),
        .ID_ALUSrcA(ID_ALUSrcA), .ID_ALUSrcB(ID_ALUSrcB), .ID_DBDataSrc(ID_DBDataSrc),
        .ID_RegDst(ID_RegDst), .ID_ALUOp(ID_ALUOp),
        .EX_valid(EX_valid), .EX_PC4(EX_PC4), .EX_ReadData1(EX_ReadData1),
        .EX_ReadData2(EX_ReadData2), .EX_Imm(EX_Imm), .EX_rs(EX_rs), .EX_rt(EX_rt),
        .EX_rd(EX_rd), .EX_UsesRt(EX_UsesRt), .EX_RegWre(EX_RegWre), .EX_mRD(EX_mRD),
        .EX_mWR(EX_mWR), .EX_ALUSrcA(EX_ALUSrcA), .EX_ALUSrcB(EX_ALUSrcB),
        .EX_DBDataSrc(EX_DBDataSrc), .EX_RegDst(EX_RegDst), .EX_ALUOp(EX_ALUOp),
        .PCWre(PCWre), .IF_ID_Wre(IF_ID_Wre), .LoadUseStall(LoadUseStall),
        .StallCount(StallCount)
    );

    // One instruction as seen by the pipeline register.
    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc4, rd1, rd2, imm;
        logic [AW-1:0] rs, rt, rd;
        logic          uses_rt, reg_wre, m_rd, m_wr, src_a, src_b, db_src;
        logic [1:0]    reg_dst;
        logic [OW-1:0] alu_op;
    } instr_t;

    typedef struct {
        logic        rst;
        logic        flush;
        instr_t      id;
        logic        exp_stall;
        instr_t      exp_ex;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t   tbl[$];
    int     checks = 0;
    int     errors = 0;
    instr_t BUB = '0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic instr_t mk(input logic v, input int rs, input int rt, input int rd,
                                  input logic ut, input logic rw, input logic mrd,
                                  input logic [OW-1:0] op, input logic [DW-1:0] d1);
        instr_t r = '0;
        r.valid = v; r.rs = AW'(rs); r.rt = AW'(rt); r.rd = AW'(rd);
        r.uses_rt = ut; r.reg_wre = rw; r.m_rd = mrd; r.alu_op = op; r.rd1 = d1;
        return r;
    endfunction

    task automatic add(input logic rst, input logic fl, input instr_t id, input logic st,
                       input instr_t ex, input logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.flush = fl; v.id = id; v.exp_stall = st; v.exp_ex = ex; v.exp_cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic fl, input instr_t r);
        Reset = rst; Flush = fl;
        ID_valid = r.valid; ID_PC4 = r.pc4; ID_ReadData1 = r.rd1; ID_ReadData2 = r.rd2;
        ID_Imm = r.imm; ID_rs = r.rs; ID_rt = r.rt; ID_rd = r.rd; ID_UsesRt = r.uses_rt;
        ID_RegWre = r.reg_wre; ID_mRD = r.m_rd; ID_mWR = r.m_wr; ID_ALUSrcA = r.src_a;
        ID_ALUSrcB = r.src_b; ID_DBDataSrc = r.db_src; ID_RegDst = r.reg_dst; ID_ALUOp = r.alu_op;
    endtask

    function automatic instr_t ex_now();
        instr_t g;
        g = {EX_valid, EX_PC4, EX_ReadData1, EX_ReadData2, EX_Imm, EX_rs, EX_rt, EX_rd,
             EX_UsesRt, EX_RegWre, EX_mRD, EX_mWR, EX_ALUSrcA, EX_ALUSrcB, EX_DBDataSrc,
             EX_RegDst, EX_ALUOp};
        return g;
    endfunction

    // Hazard as stated in instruction terms: the EX instruction is a real load
    // producing a non-zero register, and that register is one the ID
    // instruction reads.
    function automatic logic ref_hazard(input instr_t ex, input instr_t id);
        int dest;
        int srcs[$];
        if (!(ex.valid && ex.m_rd && ex.reg_wre) || ex.rt == 0 || !id.valid) return 1'b0;
        dest = int'(ex.rt);
        srcs.push_back(int'(id.rs));
        if (id.uses_rt) srcs.push_back(int'(id.rt));
        foreach (srcs[i]) if (srcs[i] == dest) return 1'b1;
        return 1'b0;
    endfunction

    // Applies one cycle: combinational checks before the edge, register checks after.
    task automatic cycle(input string tag, input logic rst, input logic fl, input instr_t id,
                         input logic st, input instr_t ex, input logic [15:0] cnt);
        drive(rst, fl, id);
        #1;
        chk({tag, " stall"}, {LoadUseStall, PCWre, IF_ID_Wre}, {st, ~st, ~st});
        @(posedge CLK);
        #1;
        chk({tag, " ex"}, ex_now(), ex);
        chk({tag, " cnt"}, StallCount, cnt);
    endtask

    instr_t P, L8, A8, L9, AI, SW, L0, Z, F, NVI, NVE, L10, LD;
    instr_t m, id;
    logic [15:0] mcnt;
    logic rst, fl, hz;

    initial begin
        P   = mk(1, 3, 4, 5, 0, 1, 0, 3'b010, 32'h11);
        L8  = mk(1, 2, 8, 5, 0, 1, 1, 3'b000, 32'h22);
        A8  = mk(1, 8, 7, 5, 1, 1, 0, 3'b001, 32'h33);
        L9  = mk(1, 1, 9, 5, 0, 1, 1, 3'b000, 32'h44);
        AI  = mk(1, 2, 9, 5, 0, 1, 0, 3'b000, 32'h55);
        SW  = mk(1, 3, 9, 5, 1, 0, 0, 3'b000, 32'h66);
        L0  = mk(1, 4, 0, 5, 0, 1, 1, 3'b000, 32'h77);
        Z   = mk(1, 0, 0, 5, 1, 1, 0, 3'b010, 32'h88);
        F   = mk(1, 5, 6, 5, 0, 1, 0, 3'b011, 32'h99);
        NVI = mk(0, 3, 4, 5, 1, 1, 1, 3'b111, 32'hAA);
        NVE = mk(0, 3, 4, 5, 1, 0, 0, 3'b000, 32'hAA);
        L10 = mk(1, 2, 10, 5, 0, 1, 1, 3'b000, 32'hBB);
        LD  = mk(1, 10, 11, 5, 0, 1, 1, 3'b000, 32'hCC);

        add(1, 0, P,   0, BUB, 0);   // reset held
        add(1, 0, P,   0, BUB, 0);
        add(0, 0, P,   0, P,   0);   // pass-through
        add(0, 0, L8,  0, L8,  0);   // lw $8
        add(0, 0, A8,  1, BUB, 1);   // add uses $8 as rs: bubble
        add(0, 0, A8,  0, A8,  1);   // add enters EX
        add(0, 0, L9,  0, L9,  1);   // lw $9
        add(0, 0, AI,  0, AI,  1);   // addi writes rt=9, not a source: no stall
        add(0, 0, L9,  0, L9,  1);
        add(0, 0, SW,  1, BUB, 2);   // sw reads rt=9: stall
        add(0, 0, L0,  0, L0,  2);   // lw $0
        add(0, 0, Z,   0, Z,   2);   // reg 0 never hazards
        add(0, 0, L8,  0, L8,  2);
        add(0, 1, A8,  1, BUB, 2);   // flush + load-use: one bubble, no count
        add(0, 1, F,   0, BUB, 2);   // flush alone
        add(0, 0, NVI, 0, NVE, 2);   // invalid ID: controls forced to 0
        add(0, 0, L8,  0, L8,  2);
        add(1, 0, A8,  1, BUB, 0);   // reset mid-stall
        add(0, 0, L8,  0, L8,  0);
        add(0, 0, L10, 0, L10, 0);   // back-to-back independent loads
        add(0, 0, LD,  1, BUB, 1);   // dependent load on address reg
        add(0, 0, LD,  0, LD,  1);

        drive(1, 0, BUB);
        @(posedge CLK);
        #1;
        foreach (tbl[i])
            cycle($sformatf("vec%0d", i), tbl[i].rst, tbl[i].flush, tbl[i].id,
                  tbl[i].exp_stall, tbl[i].exp_ex, tbl[i].exp_cnt);

        // Randomized phase against the instruction-level model.
        m    = tbl[tbl.size()-1].exp_ex;
        mcnt = tbl[tbl.size()-1].exp_cnt;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 31) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            id  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            id.valid = ($urandom_range(0, 7) != 0);
            id.rs = AW'($urandom_range(0, 3));
            id.rt = AW'($urandom_range(0, 3));
            id.m_rd = ($urandom_range(0, 2) == 0);
            hz = ref_hazard(m, id);
            if (rst) begin
                m = '0; mcnt = 0;
            end else if (fl || hz) begin
                m = '0;
                if (hz && !fl && mcnt != 16'hFFFF) mcnt = mcnt + 1;
            end else begin
                m = id;
                if (!id.valid) begin
                    m.reg_wre = 0; m.m_rd = 0; m.m_wr = 0; m.src_a = 0; m.src_b = 0;
                    m.db_src = 0; m.reg_dst = 0; m.alu_op = 0;
                end
            end
            cycle($sformatf("rnd%0d", n), rst, fl, id, hz, m, mcnt);
        end

        // Saturation: preload the counter just below its ceiling.
        cycle("sat_rst", 1, 0, BUB, hz & 1'b0, BUB, 0);
        dut.stall_count_q = 16'hFFFE;
        cycle("sat_ld1", 0, 0, L8, 0, L8, 16'hFFFE);
        cycle("sat_st1", 0, 0, A8, 1, BUB, 16'hFFFF);
        cycle("sat_go1", 0, 0, A8, 0, A8, 16'hFFFF);
        cycle("sat_ld2", 0, 0, L8, 0, L8, 16'hFFFF);
        cycle("sat_st2", 0, 0, A8, 1, BUB, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
